// File: rtl/nmos_pass_array.sv
// Behavioural array of independent NMOS pass-gate channels for SRAM models.
// Each channel is OFF, ON (source follows gate), or HOLD (node floats, then leaks).
module nmos_pass_array #(
    parameter int  N_CH        = 8,
    parameter real VDD         = 1.5,
    parameter real VSS         = 0.0,
    parameter real VTH         = 0.8,
    parameter real VT_DROP     = 0.0,
    parameter int  HOLD_CYCLES = 16,
    parameter real LEAK_STEP   = 0.1,
    localparam int CNT_W       = $clog2(N_CH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  real              vg [N_CH],
    input  real              vd [N_CH],
    output real              vs [N_CH],
    output logic [N_CH-1:0]  on_mask,
    output logic [N_CH-1:0]  hold_mask,
    output logic [N_CH-1:0]  decay_mask,
    output logic [CNT_W-1:0] on_count
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ON   = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    logic [N_CH-1:0]  on_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            state_t          state_reg;
            state_t          state_next;
            logic [HC_W-1:0] hold_cnt_reg;
            logic [HC_W-1:0] hold_cnt_next;
            real             vs_reg;
            real             vs_next;
            real             vs_on;
            real             vs_leak;

            // Candidate source levels for conduction and for one leakage step.
            always_comb begin
                vs_on = vg[gi] - VT_DROP;
                if (vs_on > VDD) begin
                    vs_on = VDD;
                end else if (vs_on < VSS) begin
                    vs_on = VSS;
                end
                vs_leak = vs_reg - LEAK_STEP;
                if (vs_leak < VSS) begin
                    vs_leak = VSS;
                end
            end

            always_comb begin
                state_next    = state_reg;
                hold_cnt_next = hold_cnt_reg;
                vs_next       = vs_reg;
                if (vg[gi] < VTH) begin
                    state_next    = S_OFF;
                    hold_cnt_next = '0;
                    vs_next       = VSS;
                end else if (vd[gi] >= VTH) begin
                    state_next    = S_ON;
                    hold_cnt_next = '0;
                    vs_next       = vs_on;
                end else begin
                    state_next = S_HOLD;
                    // Entering HOLD keeps whatever the node last held (VSS from OFF).
                    if (state_reg != S_HOLD) begin
                        hold_cnt_next = HC_W'(1);
                    end else if (hold_cnt_reg < HOLD_MAX) begin
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                    end else begin
                        vs_next = vs_leak;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg    <= S_OFF;
                    hold_cnt_reg <= '0;
                    vs_reg       <= VSS;
                end else if (en) begin
                    state_reg    <= state_next;
                    hold_cnt_reg <= hold_cnt_next;
                    vs_reg       <= vs_next;
                end
            end

            assign on_next[gi]    = (state_next == S_ON);
            assign vs[gi]         = vs_reg;
            assign on_mask[gi]    = (state_reg == S_ON);
            assign hold_mask[gi]  = (state_reg == S_HOLD);
            assign decay_mask[gi] = (state_reg == S_HOLD) && (hold_cnt_reg == HOLD_MAX);
        end
    endgenerate

    always_comb begin
        count_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            count_next = count_next + CNT_W'(on_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_next;
        end
    end

    assign on_count = count_reg;

endmodule

// File: tb/tb_nmos_pass_array.sv
// Scoreboard bench for nmos_pass_array: stimulus pushes hand-derived expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_nmos_pass_array;

    localparam int  N   = 8;
    localparam real TOL = 1e-6;

    typedef struct packed {
        logic [7:0] on;
        logic [7:0] hold;
        logic [7:0] decay;
        logic [3:0] cnt;
        logic [7:0] onb;
    } exp_bits_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b1;
    logic en_b  = 1'b0;
    real  vg [N];
    real  vd [N];
    real  vs_a [N];
    real  vs_b [N];
    logic [N-1:0] on_a, hold_a, decay_a;
    logic [N-1:0] on_b, hold_b, decay_b;
    logic [3:0]   cnt_a, cnt_b;

    // Expected state, maintained by hand in the stimulus below.
    real        exp_vs [N];
    real        exp_vsb0, exp_vsb1;
    logic [7:0] exp_on, exp_hold, exp_decay, exp_onb;
    logic [3:0] exp_cnt;

    exp_bits_t qb[$];
    real       qv[$];

    int n_cmp = 0;
    int n_bad = 0;
    int txn   = 0;

    always #5 clk = ~clk;

    nmos_pass_array #(
        .N_CH(8), .VDD(1.5), .VSS(0.0), .VTH(0.8), .VT_DROP(0.0),
        .HOLD_CYCLES(16), .LEAK_STEP(0.1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .vg(vg), .vd(vd), .vs(vs_a),
        .on_mask(on_a), .hold_mask(hold_a), .decay_mask(decay_a), .on_count(cnt_a)
    );

    nmos_pass_array #(
        .N_CH(8), .VDD(1.5), .VSS(0.0), .VTH(0.8), .VT_DROP(0.3),
        .HOLD_CYCLES(16), .LEAK_STEP(0.1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .vg(vg), .vd(vd), .vs(vs_b),
        .on_mask(on_b), .hold_mask(hold_b), .decay_mask(decay_b), .on_count(cnt_b)
    );

    task automatic chk_r(input string name, input real act, input real want);
        real diff;
        diff = (act > want) ? (act - want) : (want - act);
        n_cmp++;
        if (!(diff <= TOL)) begin
            n_bad++;
            $display("FAIL txn%0d %s: got %f, expected %f", txn, name, act, want);
        end
    endtask

    task automatic chk_v(input string name, input logic [7:0] act, input logic [7:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL txn%0d %s: got %h, expected %h", txn, name, act, want);
        end
    endtask

    // One enabled-or-frozen edge: queue the expectation for the state after it.
    task automatic tick;
        exp_bits_t e;
        @(posedge clk);
        e.on = exp_on; e.hold = exp_hold; e.decay = exp_decay; e.cnt = exp_cnt; e.onb = exp_onb;
        qb.push_back(e);
        for (int i = 0; i < N; i++) qv.push_back(exp_vs[i]);
        qv.push_back(exp_vsb0);
        qv.push_back(exp_vsb1);
        #1;
    endtask

    task automatic set_all(input real g, input real d);
        for (int i = 0; i < N; i++) begin
            vg[i] = g;
            vd[i] = d;
        end
    endtask

    task automatic exp_clear;
        for (int i = 0; i < N; i++) exp_vs[i] = 0.0;
        exp_on = 8'h00; exp_hold = 8'h00; exp_decay = 8'h00; exp_cnt = 4'd0;
    endtask

    // Retention/leak profile for a node holding v0 on the k-th edge in HOLD.
    function automatic real hold_v(input real v0, input int k);
        real v;
        v = (k <= 16) ? v0 : v0 - 0.1 * (k - 16);
        return (v < 0.0) ? 0.0 : v;
    endfunction

    initial begin : monitor
        exp_bits_t e;
        forever begin
            @(negedge clk);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                for (int i = 0; i < N; i++) chk_r($sformatf("vs[%0d]", i), vs_a[i], qv.pop_front());
                chk_r("vs_drop[0]", vs_b[0], qv.pop_front());
                chk_r("vs_drop[1]", vs_b[1], qv.pop_front());
                chk_v("on_mask", on_a, e.on);
                chk_v("hold_mask", hold_a, e.hold);
                chk_v("decay_mask", decay_a, e.decay);
                chk_v("on_count", {4'd0, cnt_a}, {4'd0, e.cnt});
                chk_v("on_mask_drop", on_b, e.onb);
                $display("txn %0d: vs0..3=%.2f,%.2f,%.2f,%.2f on=%h hold=%h decay=%h cnt=%0d",
                         txn, vs_a[0], vs_a[1], vs_a[2], vs_a[3], on_a, hold_a, decay_a, cnt_a);
                txn++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin : stim
        set_all(0.0, 0.0);
        exp_clear();
        exp_vsb0 = 0.0; exp_vsb1 = 0.0; exp_onb = 8'h00;

        // Reset and release
        #2 rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Conduction, thresholds, clamp, HOLD from OFF; second array has VT_DROP=0.3
        vg[0] = 1.5;  vd[0] = 1.5;
        vg[1] = 0.8;  vd[1] = 0.8;
        vg[4] = 0.79; vd[4] = 1.5;
        vg[5] = 2.0;  vd[5] = 1.5;
        vg[6] = 1.5;  vd[6] = 0.79;
        en_b = 1'b1;
        exp_vs[0] = 1.5; exp_vs[1] = 0.8; exp_vs[5] = 1.5;
        exp_on = 8'h23; exp_hold = 8'h40; exp_cnt = 4'd3;
        exp_vsb0 = 1.2; exp_vsb1 = 0.5; exp_onb = 8'h23;
        tick();
        en_b = 1'b0;
        set_all(0.0, 0.0);
        exp_clear();
        tick();

        // Retention and leak to the rail
        vg[2] = 1.2; vd[2] = 1.5;
        exp_vs[2] = 1.2; exp_on = 8'h04; exp_cnt = 4'd1;
        tick();
        vd[2] = 0.0;
        exp_on = 8'h00; exp_cnt = 4'd0; exp_hold = 8'h04;
        for (int k = 1; k <= 29; k++) begin
            exp_vs[2] = hold_v(1.2, k);
            exp_decay = (k >= 16) ? 8'h04 : 8'h00;
            tick();
        end

        // Re-enable from HOLD, leak to 0.7, re-enable, then fresh retention
        vd[2] = 1.5;
        exp_vs[2] = 1.2; exp_on = 8'h04; exp_hold = 8'h00; exp_decay = 8'h00; exp_cnt = 4'd1;
        tick();
        vd[2] = 0.0;
        exp_on = 8'h00; exp_cnt = 4'd0; exp_hold = 8'h04;
        for (int k = 1; k <= 21; k++) begin
            exp_vs[2] = hold_v(1.2, k);
            exp_decay = (k >= 16) ? 8'h04 : 8'h00;
            tick();
        end
        vd[2] = 1.5;
        exp_vs[2] = 1.2; exp_on = 8'h04; exp_hold = 8'h00; exp_decay = 8'h00; exp_cnt = 4'd1;
        tick();
        vd[2] = 0.0;
        exp_on = 8'h00; exp_cnt = 4'd0; exp_hold = 8'h04;
        for (int k = 1; k <= 17; k++) begin
            exp_vs[2] = hold_v(1.2, k);
            exp_decay = (k >= 16) ? 8'h04 : 8'h00;
            tick();
        end
        vg[2] = 0.0;
        exp_clear();
        tick();

        // Enable freeze mid-retention
        vg[3] = 1.0; vd[3] = 1.5;
        exp_vs[3] = 1.0; exp_on = 8'h08; exp_cnt = 4'd1;
        tick();
        vd[3] = 0.0;
        exp_on = 8'h00; exp_cnt = 4'd0; exp_hold = 8'h08;
        for (int k = 1; k <= 10; k++) tick();
        en = 1'b0;
        vg[3] = 0.0;
        vg[0] = 1.5; vd[0] = 1.5;
        for (int k = 0; k < 20; k++) tick();
        vg[0] = 0.0; vd[0] = 0.0;
        vg[3] = 1.0; vd[3] = 0.0;
        en = 1'b1;
        for (int k = 11; k <= 17; k++) begin
            exp_vs[3] = hold_v(1.0, k);
            exp_decay = (k >= 16) ? 8'h08 : 8'h00;
            tick();
        end

        // All channels leaking, then asynchronous reset between edges
        set_all(1.5, 1.5);
        for (int i = 0; i < N; i++) exp_vs[i] = 1.5;
        exp_on = 8'hFF; exp_hold = 8'h00; exp_decay = 8'h00; exp_cnt = 4'd8;
        tick();
        set_all(1.5, 0.0);
        exp_on = 8'h00; exp_cnt = 4'd0; exp_hold = 8'hFF;
        for (int k = 1; k <= 18; k++) begin
            for (int i = 0; i < N; i++) exp_vs[i] = hold_v(1.5, k);
            exp_decay = (k >= 16) ? 8'hFF : 8'h00;
            tick();
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) chk_r($sformatf("async vs[%0d]", i), vs_a[i], 0.0);
        chk_r("async vs_drop[0]", vs_b[0], 0.0);
        chk_v("async on_mask", on_a, 8'h00);
        chk_v("async hold_mask", hold_a, 8'h00);
        chk_v("async decay_mask", decay_a, 8'h00);
        chk_v("async on_count", {4'd0, cnt_a}, 8'h00);
        chk_v("async on_mask_drop", on_b, 8'h00);
        $display("txn async: vs0=%.2f on=%h hold=%h decay=%h cnt=%0d", vs_a[0], on_a, hold_a, decay_a, cnt_a);
        #20;
        rst_n = 1'b1;

        n_cmp++;
        if (qb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
